// File: rtl/mcu_mem_responder.sv
// rtl/mcu_mem_responder.sv - memory-side responder for MCU read/write handshakes
//
// Serves level-held read (i_re/i_raddr) and write (i_we/i_waddr) requests
// against a fixed-latency synchronous SRAM and returns completion pulses.
// Writes win over reads when both are pending in IDLE.
//
// Optional feature macro: MCU_MEM_ADDR_CHECK_EN (address range/alignment check).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_re, i_raddr       read request (held until o_read_complete) and byte address
//   i_we, i_waddr       write request (held until o_write_complete) and byte address
//   i_wdata             write data, valid the cycle after o_start_next_write
//   o_read_complete     one-cycle pulse, o_rdata valid
//   o_rdata             read data, held until the next read completes
//   o_start_next_write  one-cycle pulse asking b2 for the next word
//   o_write_complete    one-cycle pulse, write committed
//   o_busy              high whenever the FSM is not in IDLE
//   o_err               error flag, coincident with a completion pulse
//   mem_addr/ren/wen/wdata  registered SRAM request port
//   mem_rdata           SRAM read data, READ_LAT cycles after the mem_ren cycle

module mcu_mem_responder #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1,
  parameter int MEM_BYTES = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_read_complete,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_start_next_write,
  output logic              o_write_complete,
  output logic              o_busy,
  output logic              o_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RDONE, S_WREQ, S_WCAP, S_WR, S_WDONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               err_q, err_d;

  logic               rc_q, rc_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               start_q, start_d;
  logic               wc_q, wc_d;
  logic               busy_q, busy_d;
  logic               oerr_q, oerr_d;
  logic [ADDR_W-1:0]  maddr_q, maddr_d;
  logic               ren_q, ren_d;
  logic               wen_q, wen_d;
  logic [DATA_W-1:0]  mwdata_q, mwdata_d;

  logic               bad_raddr, bad_waddr;

`ifdef MCU_MEM_ADDR_CHECK_EN
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  // Out of range or not word aligned.
  assign bad_raddr = (i_raddr >= MEM_LIMIT) || (i_raddr[1:0] != 2'b00);
  assign bad_waddr = (i_waddr >= MEM_LIMIT) || (i_waddr[1:0] != 2'b00);
`else
  assign bad_raddr = 1'b0;
  assign bad_waddr = 1'b0;

  // MEM_BYTES only matters to the address check; reference it so the
  // parameter stays part of the interface in every build.
  if (MEM_BYTES < 0) begin : g_mem_bytes_ref
  end
`endif

  // State register plus all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      rc_q     <= 1'b0;
      rdata_q  <= '0;
      start_q  <= 1'b0;
      wc_q     <= 1'b0;
      busy_q   <= 1'b0;
      oerr_q   <= 1'b0;
      maddr_q  <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      rc_q     <= rc_d;
      rdata_q  <= rdata_d;
      start_q  <= start_d;
      wc_q     <= wc_d;
      busy_q   <= busy_d;
      oerr_q   <= oerr_d;
      maddr_q  <= maddr_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      mwdata_q <= mwdata_d;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_we) begin
          state_d = S_WREQ;
          addr_d  = i_waddr;
          err_d   = bad_waddr;
          cnt_d   = '0;
        end else if (i_re) begin
          state_d = S_RD;
          addr_d  = i_raddr;
          err_d   = bad_raddr;
          cnt_d   = '0;
        end
      end
      // Counter is 0 on the mem_ren cycle; data is due when it reaches READ_LAT.
      S_RD: begin
        if (cnt_q == CNT_W'(READ_LAT)) state_d = S_RDONE;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      S_RDONE: state_d = S_IDLE;
      S_WREQ:  state_d = S_WCAP;
      S_WCAP: begin
        state_d = S_WR;
        cnt_d   = '0;
      end
      S_WR: begin
        if (cnt_q == CNT_W'(WRITE_LAT - 1)) state_d = S_WDONE;
        else                                cnt_d   = cnt_q + 1'b1;
      end
      S_WDONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the transition.
  always_comb begin
    rc_d     = (state_d == S_RDONE);
    wc_d     = (state_d == S_WDONE);
    start_d  = (state_d == S_WREQ);
    busy_d   = (state_d != S_IDLE);
    oerr_d   = (rc_d || wc_d) && err_q;
    ren_d    = (state_q == S_IDLE) && (state_d == S_RD) && !err_d;
    // i_wdata is taken at the end of WCAP, straight into the strobe register.
    wen_d    = (state_q == S_WCAP) && !err_q;
    maddr_d  = '0;
    mwdata_d = '0;
    if (ren_d) maddr_d = addr_d;
    if (wen_d) begin
      maddr_d  = addr_q;
      mwdata_d = i_wdata;
    end
    rdata_d = rdata_q;
    if ((state_q == S_RD) && (state_d == S_RDONE))
      rdata_d = err_q ? '0 : mem_rdata;
  end

  assign o_read_complete    = rc_q;
  assign o_rdata            = rdata_q;
  assign o_start_next_write = start_q;
  assign o_write_complete   = wc_q;
  assign o_busy             = busy_q;
  assign o_err              = oerr_q;
  assign mem_addr           = maddr_q;
  assign mem_ren            = ren_q;
  assign mem_wen            = wen_q;
  assign mem_wdata          = mwdata_q;

endmodule

// File: tb/tb_mcu_mem_responder.sv
// tb/tb_mcu_mem_responder.sv - directed self-checking bench for mcu_mem_responder

module tb_mcu_mem_responder;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_re = 1'b0;
  logic [31:0] i_raddr = '0;
  logic        i_we = 1'b0;
  logic [31:0] i_waddr = '0;
  logic [31:0] i_wdata = '0;
  logic        o_read_complete;
  logic [31:0] o_rdata;
  logic        o_start_next_write;
  logic        o_write_complete;
  logic        o_busy;
  logic        o_err;
  logic [31:0] mem_addr;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  mcu_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .READ_LAT(RL), .WRITE_LAT(1), .MEM_BYTES(65536)
  ) dut (
    .clk(clk), .rst(rst),
    .i_re(i_re), .i_raddr(i_raddr),
    .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata),
    .o_read_complete(o_read_complete), .o_rdata(o_rdata),
    .o_start_next_write(o_start_next_write), .o_write_complete(o_write_complete),
    .o_busy(o_busy), .o_err(o_err),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: 256 words, fixed read latency, poison when no read is due.
  logic [31:0] sram [0:255];
  logic [31:0] rd_pipe [0:RL-1];

  always @(posedge clk) begin
    rd_pipe[0] <= mem_ren ? sram[mem_addr[9:2]] : 32'hBAD0_BAD0;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_wen) sram[mem_addr[9:2]] <= mem_wdata;
  end
  assign mem_rdata = rd_pipe[RL-1];

  // Pulse counters, sampled mid-cycle.
  int n_ren = 0, n_wen = 0, n_rc = 0, n_wc = 0, n_start = 0, n_err = 0;
  always @(negedge clk) begin
    if (mem_ren)            n_ren++;
    if (mem_wen)            n_wen++;
    if (o_read_complete)    n_rc++;
    if (o_write_complete)   n_wc++;
    if (o_start_next_write) n_start++;
    if (o_err)              n_err++;
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] all_or;
    // Power-on reset state.
    @(negedge clk);
    all_or = {31'b0, o_read_complete} | o_rdata | {31'b0, o_start_next_write} |
             {31'b0, o_write_complete} | {31'b0, o_busy} | {31'b0, o_err} |
             mem_addr | {31'b0, mem_ren} | {31'b0, mem_wen} | mem_wdata;
    tests++;
    if (all_or !== 32'h0) begin fails++; $display("FAIL reset_outputs: got %08h expected 00000000", all_or); end
    rst = 1'b0;
    idle_cycles(2);

    // Reset applied mid-read drops the transaction.
    i_raddr = 32'h110; i_re = 1'b1;
    @(negedge clk);
    tests++;
    if (o_busy !== 1'b1) begin fails++; $display("FAIL reset_pre_busy: got %b expected 1", o_busy); end
    rst = 1'b1; i_re = 1'b0;
    @(negedge clk);
    all_or = {31'b0, o_read_complete} | o_rdata | {31'b0, o_start_next_write} |
             {31'b0, o_write_complete} | {31'b0, o_busy} | {31'b0, o_err} |
             mem_addr | {31'b0, mem_ren} | {31'b0, mem_wen} | mem_wdata;
    tests++;
    if (all_or !== 32'h0) begin fails++; $display("FAIL reset_midread_outputs: got %08h expected 00000000", all_or); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tests++;
      if (o_read_complete !== 1'b0 || mem_ren !== 1'b0 || o_busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_dropped k=%0d: got rc=%b ren=%b busy=%b expected 0 0 0",
                 k, o_read_complete, mem_ren, o_busy);
      end
    end
  endtask

  task automatic test_single_read;
    sram[32'h100 >> 2] = 32'hDEAD_BEEF;
    i_raddr = 32'h100; i_re = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      tests++;
      if (mem_ren !== (k == 1)) begin fails++; $display("FAIL read_ren k=%0d: got %b expected %b", k, mem_ren, (k == 1)); end
      tests++;
      if (o_read_complete !== (k == 4)) begin fails++; $display("FAIL read_complete k=%0d: got %b expected %b", k, o_read_complete, (k == 4)); end
      tests++;
      if (o_busy !== (k <= 4)) begin fails++; $display("FAIL read_busy k=%0d: got %b expected %b", k, o_busy, (k <= 4)); end
      if (k == 1) begin
        tests++;
        if (mem_addr !== 32'h100) begin fails++; $display("FAIL read_addr: got %08h expected 00000100", mem_addr); end
        i_raddr = 32'h3FC;  // address changes mid-transaction must be ignored
      end
      if (k == 4 || k == 7) begin
        tests++;
        if (o_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL read_data k=%0d: got %08h expected deadbeef", k, o_rdata); end
      end
      if (k == 4) i_re = 1'b0;
    end
  endtask

  task automatic test_single_write;
    i_waddr = 32'h200; i_we = 1'b1; i_wdata = 32'h5555_5555;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      tests++;
      if (o_start_next_write !== (k == 1)) begin fails++; $display("FAIL write_start k=%0d: got %b expected %b", k, o_start_next_write, (k == 1)); end
      tests++;
      if (mem_wen !== (k == 3)) begin fails++; $display("FAIL write_wen k=%0d: got %b expected %b", k, mem_wen, (k == 3)); end
      tests++;
      if (o_write_complete !== (k == 4)) begin fails++; $display("FAIL write_complete k=%0d: got %b expected %b", k, o_write_complete, (k == 4)); end
      tests++;
      if (o_busy !== (k <= 4)) begin fails++; $display("FAIL write_busy k=%0d: got %b expected %b", k, o_busy, (k <= 4)); end
      if (k == 1) i_wdata = 32'h0000_00A5;
      if (k == 3) begin
        tests++;
        if (mem_addr !== 32'h200 || mem_wdata !== 32'h0000_00A5) begin
          fails++;
          $display("FAIL write_port: got addr=%08h data=%08h expected 00000200 000000a5", mem_addr, mem_wdata);
        end
        i_wdata = 32'hFFFF_FFFF;
      end
      if (k == 4) i_we = 1'b0;
    end
    tests++;
    if (sram[32'h200 >> 2] !== 32'h0000_00A5) begin fails++; $display("FAIL write_mem: got %08h expected 000000a5", sram[32'h200 >> 2]); end
  endtask

  task automatic test_simultaneous;
    int k_wc, k_ren, k_rc, rc0, wc0;
    k_wc = -1; k_ren = -1; k_rc = -1;
    rc0 = n_rc; wc0 = n_wc;
    sram[32'h104 >> 2] = 32'h1122_3344;
    i_raddr = 32'h104; i_waddr = 32'h208; i_re = 1'b1; i_we = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (o_start_next_write) i_wdata = 32'hCAFE_0208;
      if (o_write_complete) begin k_wc = k; i_we = 1'b0; end
      if (mem_ren) k_ren = k;
      if (o_read_complete) begin k_rc = k; i_re = 1'b0; end
    end
    tests++;
    if (k_wc !== 4) begin fails++; $display("FAIL both_write_first: got wc at %0d expected 4", k_wc); end
    tests++;
    if (k_ren !== 6) begin fails++; $display("FAIL both_read_ren: got ren at %0d expected 6", k_ren); end
    tests++;
    if (k_rc !== 9) begin fails++; $display("FAIL both_read_complete: got rc at %0d expected 9", k_rc); end
    tests++;
    if ((n_rc - rc0) !== 1 || (n_wc - wc0) !== 1) begin
      fails++; $display("FAIL both_pulse_count: got rc=%0d wc=%0d expected 1 1", n_rc - rc0, n_wc - wc0);
    end
    tests++;
    if (o_rdata !== 32'h1122_3344) begin fails++; $display("FAIL both_rdata: got %08h expected 11223344", o_rdata); end
    tests++;
    if (sram[32'h208 >> 2] !== 32'hCAFE_0208) begin fails++; $display("FAIL both_wmem: got %08h expected cafe0208", sram[32'h208 >> 2]); end
  endtask

  task automatic test_back_to_back;
    int s0, w0, c0, budget;
    bit done;
    s0 = n_start; w0 = n_wen; c0 = n_wc;
    for (int n = 0; n < 9; n++) begin
      i_waddr = 32'h300 + 32'(4 * n); i_we = 1'b1;
      done = 1'b0;
      budget = 0;
      while (!done && budget < 20) begin
        @(negedge clk);
        budget++;
        if (o_start_next_write) i_wdata = 32'h1000 + 32'(n);
        if (o_write_complete) begin done = 1'b1; i_we = 1'b0; end
      end
      if (!done) begin
        tests++; fails++;
        $display("FAIL burst_timeout n=%0d: got no completion expected one within 20 cycles", n);
        i_we = 1'b0;
      end
      idle_cycles(5);
    end
    tests++;
    if ((n_start - s0) !== 9 || (n_wc - c0) !== 9 || (n_wen - w0) !== 9) begin
      fails++;
      $display("FAIL burst_counts: got start=%0d wen=%0d wc=%0d expected 9 9 9",
               n_start - s0, n_wen - w0, n_wc - c0);
    end
    for (int n = 0; n < 9; n++) begin
      tests++;
      if (sram[(32'h300 + 4 * n) >> 2] !== 32'h1000 + 32'(n)) begin
        fails++;
        $display("FAIL burst_mem n=%0d: got %08h expected %08h", n,
                 sram[(32'h300 + 4 * n) >> 2], 32'h1000 + 32'(n));
      end
    end
  endtask

  task automatic test_err_flag;
    int ren0, wen0, e0;
    ren0 = n_ren; wen0 = n_wen; e0 = n_err;
    // Read out of range, then misaligned write.
    i_raddr = 32'h1_0000; i_re = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (o_read_complete) i_re = 1'b0;
    end
    i_waddr = 32'h102; i_we = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (o_start_next_write) i_wdata = 32'h7777_7777;
      if (o_write_complete) i_we = 1'b0;
    end
`ifdef MCU_MEM_ADDR_CHECK_EN
    tests++;
    if ((n_ren - ren0) !== 0 || (n_wen - wen0) !== 0 || (n_err - e0) !== 2 || o_rdata !== 32'h0) begin
      fails++;
      $display("FAIL addr_check: got ren=%0d wen=%0d err=%0d rdata=%08h expected 0 0 2 00000000",
               n_ren - ren0, n_wen - wen0, n_err - e0, o_rdata);
    end
`else
    tests++;
    if ((n_ren - ren0) !== 1 || (n_wen - wen0) !== 1 || (n_err - e0) !== 0) begin
      fails++;
      $display("FAIL no_addr_check: got ren=%0d wen=%0d err=%0d expected 1 1 0",
               n_ren - ren0, n_wen - wen0, n_err - e0);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 32'h0;
    for (int i = 0; i < RL; i++) rd_pipe[i] = 32'h0;
    @(negedge clk);
    test_reset;
    idle_cycles(2);
    test_single_read;
    idle_cycles(2);
    test_single_write;
    idle_cycles(2);
    test_simultaneous;
    idle_cycles(2);
    test_back_to_back;
    idle_cycles(2);
    test_err_flag;
    idle_cycles(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mcu_mem_responder.md
Name: mcu_mem_responder

Overview:
- Memory-side responder for the edge-detection MCU's read and write request handshakes.
- Accepts level-held read requests (re/raddr) and write requests (we/waddr), drives a fixed-latency synchronous SRAM port, and returns completion pulses.
- On reads it returns read_complete with data. On writes it returns start_next_write, then write_complete.
- Sits between the MCU plus output buffer (b2) and the external pixel memory.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
READ_LAT, 2, SRAM read latency in cycles (>=1)
WRITE_LAT, 1, SRAM write occupancy in cycles (>=1)
MEM_BYTES, 65536, addressable memory size in bytes (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
i_re  in  1  read request; held by requester until o_read_complete
i_raddr  in  ADDR_W  read byte address; stable while i_re is high
i_we  in  1  write request; held by requester until o_write_complete
i_waddr  in  ADDR_W  write byte address; stable while i_we is high
i_wdata  in  DATA_W  write data from b2; valid the cycle after o_start_next_write
o_read_complete  out  1  one-cycle pulse; o_rdata valid
o_rdata  out  DATA_W  read data; holds until the next read completes
o_start_next_write  out  1  one-cycle pulse asking b2 to present the next word
o_write_complete  out  1  one-cycle pulse; write committed
o_busy  out  1  high in any state other than IDLE
o_err  out  1  one-cycle error flag, coincident with a completion pulse
mem_addr  out  ADDR_W  SRAM address (registered)
mem_ren  out  1  SRAM read strobe, one cycle
mem_wen  out  1  SRAM write strobe, one cycle
mem_wdata  out  DATA_W  SRAM write data (registered)
mem_rdata  in  DATA_W  SRAM read data, valid READ_LAT cycles after the mem_ren cycle

Behaviour:
- Single clock domain; all outputs are registered.
- Reset (synchronous, rst=1 at a clk edge):
  - state goes to IDLE, counter to 0.
  - Every output is 0, including o_rdata, mem_addr and mem_wdata.
  - A transaction in flight when reset is applied is dropped: no completion pulse and no further strobes.
- States: IDLE, RD, RDONE, WREQ, WCAP, WR, WDONE.
- IDLE:
  - samples i_re and i_we.
  - If both are high, write has priority, so b2 keeps draining.
  - i_we=1 → WREQ, waddr latched.
  - i_re=1 → RD, raddr latched.
- Read path (request seen in IDLE at cycle 0):
  - cycle 1: RD; mem_ren=1 and mem_addr=raddr for this cycle only; counter starts.
  - Stay in RD until cycle 1+READ_LAT, then capture mem_rdata into o_rdata.
  - cycle 2+READ_LAT: RDONE; o_read_complete=1.
  - Next cycle: IDLE.
- Write path (request seen in IDLE at cycle 0):
  - cycle 1: WREQ; o_start_next_write=1.
  - cycle 2: WCAP; i_wdata is captured at the end of this cycle.
  - cycle 3: WR; mem_wen=1, mem_addr=waddr, mem_wdata=captured data on the first WR cycle only.
  - Remain in WR for WRITE_LAT cycles total.
  - cycle 3+WRITE_LAT: WDONE; o_write_complete=1.
  - Next cycle: IDLE.
- Requests are not sampled in RD, RDONE, WREQ, WCAP, WR or WDONE:
  - deasserting a request mid-transaction does not abort it;
  - changing an address mid-transaction has no effect.
- A request still high in the first IDLE cycle after a completion starts a new transaction. The requester must drop its request on the edge that follows the completion pulse.
- Back-to-back transactions: minimum one IDLE cycle between completion and the next strobe.
- Counter width is clog2(max(READ_LAT, WRITE_LAT))+1. The counter never wraps within one transaction.
- o_busy=1 exactly when state is not IDLE.

Optional Feature:
- Macro: MCU_MEM_ADDR_CHECK_EN.
- When defined, the latched address is checked in IDLE on capture. The check fails if the address is >= MEM_BYTES or addr[1:0] is not 0.
  - Failed read: no mem_ren; RD waits the normal count; o_rdata is set to 0; o_read_complete=1 with o_err=1 (normal latency).
  - Failed write: o_start_next_write still pulses (b2 stays in sync); no mem_wen; o_write_complete=1 with o_err=1.
- When undefined, no check is made, o_err is tied 0, and all addresses go to the SRAM.

Test Plan:
- Reset: assert rst for 2 cycles mid-read (state RD) → no o_read_complete; all outputs 0; o_busy=0 next cycle.
- Single read, READ_LAT=2: i_raddr=0x100, i_re held; SRAM model returns 0xDEADBEEF → mem_ren 1 cycle after request with mem_addr=0x100; o_read_complete pulse 4 cycles after request; o_rdata=0xDEADBEEF.
- Single write, WRITE_LAT=1: i_waddr=0x200, i_we held; i_wdata=0x0000_00A5 the cycle after the start pulse → o_start_next_write at +1; mem_wen at +3 with mem_wdata=0xA5 and mem_addr=0x200; o_write_complete at +4.
- Simultaneous i_re and i_we in IDLE → write path taken first; read is served after WDONE→IDLE; exactly one pulse of each completion.
- Burst of 9 writes (b2 drain) with requester dropping i_we after each complete and re-raising 5 cycles later → 9 start/complete pulse pairs, 9 mem_wen strobes, incrementing addresses written correctly.
- With MCU_MEM_ADDR_CHECK_EN, MEM_BYTES=65536: read at 0x10000 and write at 0x102 → no mem strobes; each completion carries o_err=1; o_rdata=0.
